hcu_scoreboard: RTL
===================

# hcu_scoreboard

Parametrised hazard control unit for the multi-issue RISC-machine CPU, generalising the two-lane pairing check into an N-lane, in-order issue stage with a per-register latency scoreboard. It sits between the fetch/decode lanes and the execute pipeline. Each cycle it decides which lanes of the current fetch bundle issue. It raises `fetch_next` once every valid lane of the bundle has issued, possibly over several cycles. It also tracks outstanding register writes and shared memory-port use.

## Interface
- `LANES`, 2: instructions per fetch bundle (1..4).
- `NREGS`, 8: architectural registers; `RW = $clog2(NREGS)`.
- `ALU_LAT`, 0: cycles before an ALU result can be read by a later issue (0 = fully forwarded).
- `LOAD_LAT`, 2: cycles before a load result can be read.
- `MEM_PORTS`, 1: LDR/STR lanes allowed to issue per cycle.
- `clk  in  1`: clock.
- `reset  in  1`: reset, asynchronous and active-high.
- `lane_valid  in  LANES`: lane holds a real instruction.
- `lane_rs1 / lane_rs2  in  LANES*RW`: source register indices, lane i at `[i*RW +: RW]`.
- `lane_rs1_en / lane_rs2_en  in  LANES`: source is actually read.
- `lane_rd  in  LANES*RW`: destination register index.
- `lane_rd_en  in  LANES`: lane writes `lane_rd`.
- `lane_mem  in  LANES`: lane is LDR or STR.
- `lane_load  in  LANES`: lane is LDR; its write uses `LOAD_LAT`.
- `stall_in  in  1`: downstream pipeline stall.
- `flush  in  1`: discard the current bundle (branch redirect).
- `issue_mask  out  LANES`: lanes issuing this cycle.
- `fetch_next  out  1`: bundle complete; upstream presents the next bundle on the next cycle.
- `busy_vec  out  NREGS`: register has a nonzero scoreboard counter.

## Operation
- State:
  - `done_mask[LANES]` marks lanes of the current bundle already issued.
  - `cnt[NREGS]` holds one counter per register, width `$clog2(max(ALU_LAT,LOAD_LAT)+1)`.
- Lane i is eligible this cycle when all of the following hold:
  - `lane_valid[i]`, `!done_mask[i]`, `!stall_in`, `!flush`, `!reset`.
  - Each enabled source has `cnt == 0`.
  - If `lane_rd_en[i]`, `cnt[lane_rd] == 0` (WAW stall).
  - No earlier lane j<i that is valid and not yet done writes a register that lane i reads or writes. This intra-bundle RAW/WAW check applies even when j issues this same cycle; there is no same-cycle bypass.
  - If `lane_mem[i]`, fewer than `MEM_PORTS` memory lanes are issuing at indices below i.
- In-order issue: `issue_mask[i] = eligible[i] && (lane i-1 done, issuing, or invalid)`, evaluated recursively from lane 0. A held lane blocks every later lane.
- `fetch_next = !flush && !stall_in && ((done_mask | issue_mask) covers every valid lane)`. A bundle with no valid lanes completes immediately unless stalled.
- `done_mask` update, first matching rule wins:
  - `flush`: clear to 0.
  - `fetch_next`: clear to 0.
  - Otherwise: `done_mask |= issue_mask`.
- Scoreboard, each cycle, for each register r:
  - If `stall_in`: hold the value.
  - Else if an issuing lane writes r: load `LOAD_LAT` if that lane is a load, else `ALU_LAT`.
  - Else if `cnt != 0`: decrement.
- The WAW rule guarantees at most one loader per register per cycle. A load and a decrement never collide.
- `flush` does not clear counters, because instructions already issued still write back.
- R0 is an ordinary register with no special casing.

## Timing
- `issue_mask`, `fetch_next` and `busy_vec` are combinational from registered state and current inputs. No output registers.
- During reset all outputs are 0. Asynchronous reset clears `done_mask` and all `cnt`, including mid-bundle and mid-load.
- A writer issuing in cycle t sets `cnt = L` at edge t+1. A dependent reader can issue in cycle t+1+L (t+1 when L=0).
- While `stall_in` is high, counters freeze and nothing issues.
- A partial bundle must be held stable by upstream until `fetch_next`.

## Test plan
All scenarios use LANES=2, NREGS=8, ALU_LAT=0, LOAD_LAT=2, MEM_PORTS=1.
- Reset held, then released. Bundle lane0 MOV R1,#2 and lane1 ADD R4,R1-independent (reads R2). -> During reset all outputs are 0. After release: `issue_mask=2'b11`, `fetch_next=1` in the same cycle, `busy_vec=0`.
- Lane0 STR R1 and lane1 LDR R3 (both memory). -> Cycle 1: `issue_mask=01`, `fetch_next=0`. Cycle 2: `issue_mask=10`, `fetch_next=1`. Cycles 3-4: `busy_vec[3]=1`. Cycle 5: `busy_vec=0`.
- LDR R3 issues in cycle t; next bundle is ADD R4,R3 plus an independent op. -> `issue_mask=00` in t+1 and t+2; `issue_mask=11` and `fetch_next=1` in t+3.
- Intra-bundle RAW: lane0 ADD R4,R2,R3 and lane1 STR R4. -> `issue_mask=01`, then `issue_mask=10` with `fetch_next=1`.
- LDR R0 issues, then `stall_in` is held for 3 cycles. -> `cnt[0]` stays at 2 throughout and `issue_mask=00`. After release it decrements 2→1→0.
- Lane0 issued and lane1 held. Assert `flush`, then separately assert `reset` mid-load. -> Flush: `done_mask` is 0 next cycle, the same bundle re-issues from lane0, `busy_vec` is unchanged. Reset: `busy_vec` drops to 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/hcu_scoreboard.sv
// N-lane in-order issue stage with a per-register latency scoreboard.
// Decides which lanes of the held fetch bundle issue and when the bundle is complete.

module hcu_sb_cnt #(
    parameter int CW       = 2,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          wr,
    input  logic          ld,
    output logic [CW-1:0] cnt
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!stall) begin
            if (wr)
                cnt <= ld ? CW'(LOAD_LAT) : CW'(ALU_LAT);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end
endmodule

module hcu_scoreboard #(
    parameter int LANES     = 2,
    parameter int NREGS     = 8,
    parameter int ALU_LAT   = 0,
    parameter int LOAD_LAT  = 2,
    parameter int MEM_PORTS = 1,
    parameter int RW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    lane_valid,
    input  logic [LANES*RW-1:0] lane_rs1,
    input  logic [LANES*RW-1:0] lane_rs2,
    input  logic [LANES-1:0]    lane_rs1_en,
    input  logic [LANES-1:0]    lane_rs2_en,
    input  logic [LANES*RW-1:0] lane_rd,
    input  logic [LANES-1:0]    lane_rd_en,
    input  logic [LANES-1:0]    lane_mem,
    input  logic [LANES-1:0]    lane_load,
    input  logic                stall_in,
    input  logic                flush,
    output logic [LANES-1:0]    issue_mask,
    output logic                fetch_next,
    output logic [NREGS-1:0]    busy_vec
);
    localparam int MAXLAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int CW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);

    logic [NREGS-1:0][CW-1:0] cnt;
    logic [NREGS-1:0]         wr_hit, wr_ld;
    logic [LANES-1:0]         done_mask, elig;
    logic                     prev_ok;
    int                       mem_used;

    hcu_sb_cnt #(.CW(CW), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) u_cnt [NREGS-1:0] (
        .clk   (clk),
        .reset (reset),
        .stall (stall_in),
        .wr    (wr_hit),
        .ld    (wr_ld),
        .cnt   (cnt)
    );

    // Lanes are walked in order so memory-port use and the in-order chain see earlier decisions.
    always_comb begin
        issue_mask = '0;
        elig       = '0;
        mem_used   = 0;
        prev_ok    = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            elig[i] = lane_valid[i] && !done_mask[i] && !stall_in && !flush && !reset;
            if (lane_rs1_en[i] && cnt[lane_rs1[i*RW +: RW]] != '0) elig[i] = 1'b0;
            if (lane_rs2_en[i] && cnt[lane_rs2[i*RW +: RW]] != '0) elig[i] = 1'b0;
            if (lane_rd_en[i]  && cnt[lane_rd[i*RW +: RW]]  != '0) elig[i] = 1'b0;
            // No same-cycle bypass: a pending earlier writer blocks even if it issues now.
            for (int j = 0; j < i; j++) begin
                if (lane_valid[j] && !done_mask[j] && lane_rd_en[j] &&
                    ((lane_rs1_en[i] && lane_rs1[i*RW +: RW] == lane_rd[j*RW +: RW]) ||
                     (lane_rs2_en[i] && lane_rs2[i*RW +: RW] == lane_rd[j*RW +: RW]) ||
                     (lane_rd_en[i]  && lane_rd[i*RW +: RW]  == lane_rd[j*RW +: RW])))
                    elig[i] = 1'b0;
            end
            if (lane_mem[i] && mem_used >= MEM_PORTS) elig[i] = 1'b0;
            issue_mask[i] = elig[i] && prev_ok;
            if (issue_mask[i] && lane_mem[i]) mem_used++;
            prev_ok = done_mask[i] || issue_mask[i] || !lane_valid[i];
        end
    end

    always_comb begin
        wr_hit = '0;
        wr_ld  = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int i = 0; i < LANES; i++) begin
                if (issue_mask[i] && lane_rd_en[i] && lane_rd[i*RW +: RW] == RW'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_ld[r]  = lane_load[i];
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREGS; r++)
            busy_vec[r] = (cnt[r] != '0);
    end

    assign fetch_next = !flush && !stall_in && !reset &&
                        (&(done_mask | issue_mask | ~lane_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            done_mask <= '0;
        else if (flush || fetch_next)
            done_mask <= '0;
        else
            done_mask <= done_mask | issue_mask;
    end
endmodule
